// File: rtl/fifo_sync_fwft.sv
// rtl/fifo_sync_fwft.sv - single-clock first-word-fall-through FIFO with inferred block RAM
module fifo_sync_fwft #(
   parameter int DATA_WIDTH        = 128,
   parameter int DEPTH_LOG2        = 9,
   parameter int PROG_FULL_THRESH  = 496,
   parameter int PROG_EMPTY_THRESH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  full,
   output logic                  prog_full,
   output logic                  prog_empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] CAP   = DEPTH[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0] PF_T  = PROG_FULL_THRESH[DEPTH_LOG2:0];
   localparam logic [DEPTH_LOG2:0] PE_T  = PROG_EMPTY_THRESH[DEPTH_LOG2:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   ram_level, count_next;
   logic [DATA_WIDTH-1:0] mid_data;
   logic                  mid_valid;
   logic                  wr_acc, pop, mid_to_out, ram_rd;

   // Two-stage prefetch: RAM read register (mid) feeding the output register.
   assign wr_acc     = wr_en & ~full;
   assign pop        = rd_en & ~empty;
   assign mid_to_out = mid_valid & (empty | pop);
   assign ram_rd     = (ram_level != '0) & (~mid_valid | mid_to_out);

   always_comb begin
      count_next = count;
      if (wr_acc && !pop)
         count_next = count + 1'b1;
      else if (!wr_acc && pop)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (ram_rd)
         mid_data <= mem[rd_ptr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ram_level  <= '0;
         mid_valid  <= 1'b0;
         dout       <= '0;
         empty      <= 1'b1;
         full       <= 1'b0;
         prog_full  <= 1'b0;
         prog_empty <= 1'b1;
         count      <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (ram_rd)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, ram_rd})
            2'b10:   ram_level <= ram_level + 1'b1;
            2'b01:   ram_level <= ram_level - 1'b1;
            default: ram_level <= ram_level;
         endcase

         if (ram_rd)
            mid_valid <= 1'b1;
         else if (mid_to_out)
            mid_valid <= 1'b0;

         if (mid_to_out) begin
            dout  <= mid_data;
            empty <= 1'b0;
         end else if (pop) begin
            empty <= 1'b1;
         end

         count      <= count_next;
         full       <= (count_next == CAP);
         prog_full  <= (count_next >= PF_T);
         prog_empty <= (count_next <= PE_T);

         // A fresh error in the same cycle as err_clr keeps the flag set.
         if (wr_en && full)
            overflow <= 1'b1;
         else if (err_clr)
            overflow <= 1'b0;
         if (rd_en && empty)
            underflow <= 1'b1;
         else if (err_clr)
            underflow <= 1'b0;
      end
   end

endmodule
